reg_writeback_queue: RTL and testbench

- Write-side initiator for the 8-bit register file. It buffers write-back requests from execution units (ALU, memory, multi-cycle ops) in a small in-order FIFO.
- It drains the FIFO into the register file write port (write_reg / write_data / reg_write_en), at most one write per clock.
- It provides a read-bypass lookup, so decode sees values still queued and not yet written.
- It sits between the execute/memory stages and register_file.

---
 rtl/reg_writeback_queue.sv | 119 +++++++++++
 tb/tb_reg_writeback_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_queue
// Purpose  : In-order write-back FIFO draining into the register file write
//            port, with a two-port read bypass over the queued entries.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_reg,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic                  fwd_hit1,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data2,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] ent_reg_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_reg_d  [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push;
  logic                  pop;

  assign in_ready = (count_q != DEPTH_CNT);
  assign push     = in_valid & in_ready;
  // A reset cycle must not emit a write for entries that are being discarded.
  assign pop      = (count_q != '0) & ~hold & ~rst;

  assign reg_write_en = pop;
  assign write_reg    = pop ? ent_reg_q[head_q]  : '0;
  assign write_data   = pop ? ent_data_q[head_q] : '0;
  assign count        = count_q;

  always_comb begin
    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (push) begin
      ent_reg_d[tail_q]  = in_reg;
      ent_data_d[tail_q] = in_data;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ent_reg_q  <= ent_reg_d;
      ent_data_q <= ent_data_d;
    end
  end

  // Walk oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = head_q;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (ent_reg_q[idx] == read_reg1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = ent_data_q[idx];
        end
        if (ent_reg_q[idx] == read_reg2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = ent_data_q[idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_queue
// Purpose  : Self-checking bench: directed vector table, hand sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_reg;
  logic [7:0] in_data;
  logic       hold;
  logic [2:0] write_reg;
  logic [7:0] write_data;
  logic       reg_write_en;
  logic [2:0] read_reg1;
  logic [2:0] read_reg2;
  logic       fwd_hit1;
  logic [7:0] fwd_data1;
  logic       fwd_hit2;
  logic [7:0] fwd_data2;
  logic [3:0] count;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .hold(hold),
    .write_reg(write_reg), .write_data(write_data), .reg_write_en(reg_write_en),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  typedef struct {
    int rst, valid, ireg, idata, hold, rr1, rr2;
    int rdy, we, wr, wd, h1, f1, h2, f2, cnt;
  } vec_t;

  typedef struct { int r; int d; } ent_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tb_rf [8];
  ent_t       mq [$];
  vec_t       vecs [27];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs from the abstract queue: size, front element, newest match.
  function automatic vec_t model_exp(input vec_t v);
    vec_t e = v;
    int   n = mq.size();
    e.rdy = (n != 4) ? 1 : 0;
    e.we  = (n != 0 && v.hold == 0 && v.rst == 0) ? 1 : 0;
    e.wr  = e.we ? mq[0].r : 0;
    e.wd  = e.we ? mq[0].d : 0;
    e.h1 = 0; e.f1 = 0; e.h2 = 0; e.f2 = 0;
    for (int k = 0; k < n; k++) begin
      if (mq[k].r == v.rr1) begin e.h1 = 1; e.f1 = mq[k].d; end
      if (mq[k].r == v.rr2) begin e.h2 = 1; e.f2 = mq[k].d; end
    end
    e.cnt = n;
    return e;
  endfunction

  task automatic model_update(input vec_t v);
    int n;
    n = mq.size();
    if (v.rst != 0) begin
      mq.delete();
    end else begin
      if (n != 0 && v.hold == 0) void'(mq.pop_front());
      if (v.valid != 0 && n != 4) mq.push_back('{v.ireg, v.idata});
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    rst       = v.rst[0];
    in_valid  = v.valid[0];
    in_reg    = 3'(v.ireg);
    in_data   = 8'(v.idata);
    hold      = v.hold[0];
    read_reg1 = 3'(v.rr1);
    read_reg2 = 3'(v.rr2);
    #3;
    check({tag, ".in_ready"},     32'(in_ready),     32'(v.rdy));
    check({tag, ".reg_write_en"}, 32'(reg_write_en), 32'(v.we));
    check({tag, ".write_reg"},    32'(write_reg),    32'(v.wr));
    check({tag, ".write_data"},   32'(write_data),   32'(v.wd));
    check({tag, ".fwd_hit1"},     32'(fwd_hit1),     32'(v.h1));
    check({tag, ".fwd_data1"},    32'(fwd_data1),    32'(v.f1));
    check({tag, ".fwd_hit2"},     32'(fwd_hit2),     32'(v.h2));
    check({tag, ".fwd_data2"},    32'(fwd_data2),    32'(v.f2));
    check({tag, ".count"},        32'(count),        32'(v.cnt));
    if (reg_write_en === 1'b1) tb_rf[write_reg] = write_data;
    model_update(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 8; i++) tb_rf[i] = 8'h00;

    //           rst v reg data   hold r1 r2 | rdy we wr wd    h1 f1    h2 f2    cnt
    vecs[0]  = '{0, 0, 0, 0,     0, 0, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[1]  = '{0, 1, 2, 'hAA,  0, 2, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[2]  = '{0, 0, 0, 0,     0, 2, 0,   1, 1, 2, 'hAA,  1, 'hAA,  0, 0,     1};
    vecs[3]  = '{0, 0, 0, 0,     0, 2, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[4]  = '{0, 1, 1, 'h11,  1, 0, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[5]  = '{0, 1, 2, 'h22,  1, 1, 2,   1, 0, 0, 0,     1, 'h11,  0, 0,     1};
    vecs[6]  = '{0, 1, 3, 'h33,  1, 2, 3,   1, 0, 0, 0,     1, 'h22,  0, 0,     2};
    vecs[7]  = '{0, 1, 4, 'h44,  1, 3, 1,   1, 0, 0, 0,     1, 'h33,  1, 'h11,  3};
    vecs[8]  = '{0, 1, 5, 'h55,  1, 4, 5,   0, 0, 0, 0,     1, 'h44,  0, 0,     4};
    vecs[9]  = '{0, 1, 5, 'h55,  0, 1, 5,   0, 1, 1, 'h11,  1, 'h11,  0, 0,     4};
    vecs[10] = '{0, 1, 6, 'h66,  0, 0, 4,   1, 1, 2, 'h22,  0, 0,     1, 'h44,  3};
    vecs[11] = '{0, 0, 0, 0,     0, 6, 5,   1, 1, 3, 'h33,  1, 'h66,  0, 0,     3};
    vecs[12] = '{0, 0, 0, 0,     0, 3, 0,   1, 1, 4, 'h44,  0, 0,     0, 0,     2};
    vecs[13] = '{0, 0, 0, 0,     0, 6, 0,   1, 1, 6, 'h66,  1, 'h66,  0, 0,     1};
    vecs[14] = '{0, 0, 0, 0,     0, 6, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[15] = '{0, 1, 3, 'hFF,  1, 0, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[16] = '{0, 1, 3, 'h0F,  1, 3, 0,   1, 0, 0, 0,     1, 'hFF,  0, 0,     1};
    vecs[17] = '{0, 0, 0, 0,     1, 3, 5,   1, 0, 0, 0,     1, 'h0F,  0, 0,     2};
    vecs[18] = '{0, 0, 0, 0,     0, 3, 5,   1, 1, 3, 'hFF,  1, 'h0F,  0, 0,     2};
    vecs[19] = '{0, 0, 0, 0,     0, 3, 5,   1, 1, 3, 'h0F,  1, 'h0F,  0, 0,     1};
    vecs[20] = '{0, 0, 0, 0,     0, 3, 5,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[21] = '{0, 1, 1, 'hA1,  1, 0, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[22] = '{0, 1, 2, 'hA2,  1, 1, 0,   1, 0, 0, 0,     1, 'hA1,  0, 0,     1};
    vecs[23] = '{0, 1, 7, 'hA7,  1, 7, 2,   1, 0, 0, 0,     0, 0,     1, 'hA2,  2};
    vecs[24] = '{1, 1, 4, 'h99,  0, 7, 1,   1, 0, 0, 0,     1, 'hA7,  1, 'hA1,  3};
    vecs[25] = '{0, 0, 0, 0,     0, 7, 1,   1, 0, 0, 0,     0, 0,     0, 0,     0};
    vecs[26] = '{0, 0, 0, 0,     0, 2, 0,   1, 0, 0, 0,     0, 0,     0, 0,     0};

    rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; hold = 1'b0;
    read_reg1 = '0; read_reg2 = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      if (i == 3) check("rf_reg2_after_write", 32'(tb_rf[2]), 32'h0000_00AA);
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back pushes with hold low: one-cycle latency, in order, across wrap.
    for (int i = 0; i <= 11; i++) begin
      v = '{0, (i < 10) ? 1 : 0, i % 8, i, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      v = model_exp(v);
      v.rdy = 1;
      v.we  = (i >= 1 && i <= 10) ? 1 : 0;
      v.wr  = v.we ? (i - 1) % 8 : 0;
      v.wd  = v.we ? (i - 1) : 0;
      v.cnt = (i >= 1 && i <= 10) ? 1 : 0;
      run_vec($sformatf("stream%0d", i), v);
    end
    check("rf_reg1_last_wins", 32'(tb_rf[1]), 32'd9);
    check("rf_reg0_stream",    32'(tb_rf[0]), 32'd8);

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      v.rst   = ($urandom_range(0, 49) == 0) ? 1 : 0;
      v.valid = ($urandom_range(0, 9) < 6) ? 1 : 0;
      v.ireg  = int'($urandom_range(0, 7));
      v.idata = int'($urandom_range(0, 255));
      v.hold  = ($urandom_range(0, 9) < 3) ? 1 : 0;
      v.rr1   = int'($urandom_range(0, 7));
      v.rr2   = int'($urandom_range(0, 7));
      v = model_exp(v);
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
